// File: rtl/fifo_sync_buf_pkg.sv
// Shared types for the single-clock FIFO buffer.
// Operation encoding used by the pointer and count logic.
package fifo_sync_buf_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e op_decode(
        input logic wr_ok,
        input logic rd_ok
    );
        return fifo_op_e'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/fifo_sync_buf_sdp_ram.sv
// Simple-dual-port RAM: synchronous write, registered read
// with read enable and an async-reset output register.
module fifo_sdp_ram #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register only; the array itself is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_buf.sv
// Single-clock FIFO with registered read, full/empty flags,
// word-count water levels and almost-full/almost-empty flags.
module fifo_sync_buf
    import fifo_sync_buf_pkg::*;
#(
    parameter int DEPTH_WIDTH      = 11,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic [DEPTH_WIDTH:0]  wr_water_level,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  rd_empty,
    output logic [DEPTH_WIDTH:0]  rd_water_level,
    output logic                  almost_empty
);

    localparam logic [DEPTH_WIDTH:0] FULL_CNT =
        {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AF_CNT =
        (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_CNT =
        (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic                   wr_ok;
    logic                   rd_ok;
    fifo_op_e               op;

    // Acceptance uses flags decoded from the count before the edge.
    assign wr_ok = wr_en & ~wr_full;
    assign rd_ok = rd_en & ~rd_empty;
    assign op    = op_decode(wr_ok, rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                OP_WR: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                OP_RD: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                OP_NONE: begin
                end
            endcase
        end
    end

    assign wr_full        = (count == FULL_CNT);
    assign rd_empty       = (count == '0);
    assign wr_water_level = count;
    assign rd_water_level = count;
    assign almost_full    = (count >= AF_CNT);
    assign almost_empty   = (count <= AE_CNT);

    fifo_sdp_ram #(
        .ADDR_WIDTH (DEPTH_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_sync_buf.sv
// Self-checking bench for fifo_sync_buf: vector table plus
// queue-model scoreboard for the multi-cycle sequences.
module tb_fifo_sync_buf;

    localparam int DW    = 11;
    localparam int WW    = 16;
    localparam int DEPTH = 1 << DW;
    localparam int AFN   = 1020;
    localparam int AEN   = 4;

    logic          clk;
    logic          rst_n;
    logic [WW-1:0] wr_data;
    logic          wr_en;
    logic          wr_full;
    logic [DW:0]   wr_water_level;
    logic          almost_full;
    logic [WW-1:0] rd_data;
    logic          rd_en;
    logic          rd_empty;
    logic [DW:0]   rd_water_level;
    logic          almost_empty;

    int checks;
    int failures;

    logic [WW-1:0] model_q[$];
    logic [WW-1:0] sb_q[$];
    logic [WW-1:0] model_rd;

    typedef struct {
        logic          we;
        logic [WW-1:0] wd;
        logic          re;
        int            exp_level;
        logic [WW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    fifo_sync_buf #(
        .DEPTH_WIDTH      (DW),
        .DATA_WIDTH       (WW),
        .ALMOST_FULL_NUM  (AFN),
        .ALMOST_EMPTY_NUM (AEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        chk("wr_level", int'(wr_water_level), n);
        chk("rd_level", int'(rd_water_level), n);
        chk("wr_full", int'(wr_full), int'(n == DEPTH));
        chk("rd_empty", int'(rd_empty), int'(n == 0));
        chk("almost_full", int'(almost_full), int'(n >= AFN));
        chk("almost_empty", int'(almost_empty), int'(n <= AEN));
    endtask

    task automatic step(input logic we, input logic [WW-1:0] wd,
                        input logic re);
        bit            w_ok;
        bit            r_ok;
        logic [WW-1:0] d;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        w_ok = we && (model_q.size() < DEPTH);
        r_ok = re && (model_q.size() > 0);
        if (r_ok) begin
            d = model_q.pop_front();
            sb_q.push_back(d);
        end
        if (w_ok) model_q.push_back(wd);
        @(posedge clk);
        #1;
        if (r_ok) begin
            d = sb_q.pop_front();
            model_rd = d;
            chk("rd_data", int'(rd_data), int'(d));
        end else begin
            chk("rd_hold", int'(rd_data), int'(model_rd));
        end
        check_flags();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_rd = '0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;

        vecs[0] = '{1'b1, 16'hA001, 1'b1, 1, 16'h0000};
        vecs[1] = '{1'b1, 16'hB002, 1'b0, 2, 16'h0000};
        vecs[2] = '{1'b1, 16'hC003, 1'b1, 2, 16'hA001};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1, 16'hB002};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 0, 16'hC003};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 0, 16'hC003};

        #200;
        chk("rst_rd_data", int'(rd_data), 0);
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].re);
            chk("vec_level", int'(wr_water_level), vecs[i].exp_level);
            chk("vec_rd_data", int'(rd_data), int'(vecs[i].exp_rd));
        end

        for (int i = 0; i <= DEPTH; i++)
            step(1'b1, 16'(32'hFFFF - i), 1'b0);
        chk("fill_full", int'(wr_full), 1);
        chk("fill_level", int'(wr_water_level), DEPTH);
        for (int i = 0; i <= DEPTH; i++)
            step(1'b0, '0, 1'b1);
        chk("drain_hold", int'(rd_data), 16'hF800);
        chk("drain_empty", int'(rd_empty), 1);

        for (int i = 0; i < 10; i++)
            step(1'b1, 16'(i * 3 + 1), 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'(16'h7000 + i), 1'b1);
        chk("lvl10_level", int'(rd_water_level), 10);
        for (int i = 0; i < 10; i++)
            step(1'b0, '0, 1'b1);

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 16'(i) ^ 16'h5A5A, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1);
        chk("full_both_level", int'(wr_water_level), DEPTH - 1);
        chk("full_both_rd", int'(rd_data), 16'h5A5A);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, '0, 1'b1);

        step(1'b1, 16'hBEEF, 1'b1);
        chk("empty_both_level", int'(wr_water_level), 1);
        chk("empty_both_rd", int'(rd_data), int'(16'(16'h5A5A ^ 16'(DEPTH - 1))));
        step(1'b0, '0, 1'b1);
        chk("empty_both_word", int'(rd_data), 16'hBEEF);

        for (int i = 0; i < 100; i++)
            step(1'b1, 16'(16'h3000 + i), 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_rd = '0;
        chk("mid_rst_empty", int'(rd_empty), 1);
        chk("mid_rst_rd_data", int'(rd_data), 0);
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_word", int'(rd_data), 16'h1234);

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync_buf.md
Name: fifo_sync_buf

Overview:
- Single-clock, first-word-fall-through-free FIFO: 2048 x 16 bits by default, with full/empty flags, word-count water levels and programmable almost-full/almost-empty flags.
- Drop-in replacement for the vendor FIFO IP in the data path.
- Write port and read port share one clock.
- Storage is an inferred simple-dual-port RAM with a registered read.

Parameters:
- DEPTH_WIDTH, 11: address width; depth = 2**DEPTH_WIDTH = 2048 words.
- DATA_WIDTH, 16: width of wr_data and rd_data.
- ALMOST_FULL_NUM, 1020: almost_full threshold, in words.
- ALMOST_EMPTY_NUM, 4: almost_empty threshold, in words.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 2**DEPTH_WIDTH words.
- wr_water_level  out  DEPTH_WIDTH+1  stored word count.
- almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_en  in  1  read request.
- rd_empty  out  1  FIFO holds 0 words.
- rd_water_level  out  DEPTH_WIDTH+1  stored word count (identical to wr_water_level).
- almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count cleared; rd_data = 0; rd_empty = 1; wr_full = 0; both water levels = 0; almost_empty = 1; almost_full = 0. Reset mid-operation discards all contents immediately.
- State: wr_ptr and rd_ptr, each DEPTH_WIDTH bits, wrapping modulo depth; count, DEPTH_WIDTH+1 bits, range 0..2048.
- Write acceptance: wr_ok = wr_en & !wr_full, using the full flag from before the edge. On wr_ok: mem[wr_ptr] <= wr_data, wr_ptr++.
- Write to a full FIFO: dropped silently; no state change.
- Read acceptance: rd_ok = rd_en & !rd_empty. On rd_ok: rd_data <= mem[rd_ptr] (latency 1: valid in the cycle after rd_en is sampled), rd_ptr++.
- Read of an empty FIFO: ignored; rd_data holds its last value.
- Count update: +1 if only wr_ok; -1 if only rd_ok; unchanged if both or neither.
- Flag derivation: all flags and water levels are combinational decodes of the count register, so they update one cycle after the accepted operation. wr_full = (count == 2**DEPTH_WIDTH); rd_empty = (count == 0).
- Simultaneous write and read when full: the read is accepted, the write is rejected (flags from before the edge).
- Simultaneous write and read when empty: the write is accepted, the read is rejected.
- Same-address access: write and read never hit the same location in one cycle while both are accepted. No RAM bypass is required.
- Latency: a word written at edge N can be read at edge N+1 (rd_empty deasserts after edge N); rd_data is valid after edge N+1.
- Ordering: strict FIFO. Pointer wrap-around is transparent.

Decomposition:
- No shared package needed; the thresholds are parameters.
- One sub-module is natural: fifo_sdp_ram, a DEPTH x DATA_WIDTH simple-dual-port RAM with synchronous write, registered read with read enable, and an async-reset output register.
- Pointer, count and flag logic stays in fifo_sync_buf.

Test Plan:
- Reset: hold rst_n=0 for 200 ns -> rd_empty=1, wr_full=0, levels=0, almost_empty=1, almost_full=0, rd_data=0.
- Fill: 2049 consecutive writes of 0xFFFF, 0xFFFE, ... -> wr_full=1 after the 2048th; the 2049th (0xF7FF) is dropped. Level = 2048; almost_full rises when the level reaches 1020; almost_empty falls when the level reaches 5.
- Drain: 2049 consecutive reads -> rd_data the cycle after each accepted read = 0xFFFF, 0xFFFE, ..., 0xF800 with no mismatches. rd_empty=1 after the 2048th read; the 2049th read is ignored and rd_data holds 0xF800.
- Simultaneous read and write at level 10 -> level stays 10; data order preserved.
- Simultaneous read and write when full -> read returns the oldest word; write dropped; level = 2047.
- Simultaneous read and write when empty -> write accepted; rd_data unchanged; level = 1.
- Reset asserted with 100 words stored -> immediately empty; a subsequent write then read returns the new word.
